rename_map_nway: RTL
====================

# rename_map_nway

Parametrised multi-lane register alias table with internal branch checkpoints for the out-of-order core. It renames up to `DISPATCH_W` instructions per cycle and resolves intra-group dependencies. It tracks per-architectural-register readiness from `CDB_PORTS` broadcast buses. Mispredict recovery is single-cycle, from a circular checkpoint store, so no external BRAT is needed. It sits between decode/free list and the reservation stations/ROB.

## Interface
- `PHYS_W`, 6: physical register index width; must be ≥5.
- `DISPATCH_W`, 2: rename lanes per cycle; lane 0 is oldest.
- `CDB_PORTS`, 4: CDB broadcast ports.
- `CKPT_DEPTH`, 4: checkpoint slots; must be a power of 2.
- `CKPT_W`, $clog2(CKPT_DEPTH): checkpoint id width.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `disp_valid`  in  [DISPATCH_W]  lane carries an instruction.
- `disp_rs1`, `disp_rs2`  in  [DISPATCH_W][5]  architectural sources.
- `disp_rd`  in  [DISPATCH_W][5]  architectural destination; 0 means no rename.
- `disp_pd`  in  [DISPATCH_W][PHYS_W]  physical register popped from the free list for the lane.
- `disp_ckpt`  in  [DISPATCH_W]  lane is a branch; take a snapshot. At most one per cycle.
- `ps1`, `ps2`  out  [DISPATCH_W][PHYS_W]  renamed sources.
- `ps1_ready`, `ps2_ready`  out  [DISPATCH_W]  source value already available.
- `ckpt_alloc_id`  out  CKPT_W  id assigned to this cycle's checkpoint (tail).
- `ckpt_full`  out  1  all slots in use.
- `cdb_valid`  in  [CDB_PORTS]  broadcast valid.
- `cdb_arch`  in  [CDB_PORTS][5]  destination architectural register.
- `cdb_phys`  in  [CDB_PORTS][PHYS_W]  destination physical register.
- `ckpt_release`  in  1  oldest branch resolved correctly; free the head slot.
- `flush_valid`  in  1  mispredict.
- `flush_ckpt_id`  in  CKPT_W  checkpoint of the mispredicted branch.

## Operation
- State:
  - `map[32]` of PHYS_W bits.
  - `rdy[32]`.
  - Checkpoint arrays `cmap[CKPT_DEPTH][32]` and `crdy[CKPT_DEPTH][32]`.
  - `head`/`tail` pointers of CKPT_W+1 bits; the extra MSB distinguishes full from empty.
- Reset: `map[i]=i`, `rdy='1`, `head=tail=0`, all checkpoint contents 0. Reset values of the outputs follow from this state.
- Source lookup for lane j, rs1 (rs2 identical):
  - If rs1==0: `ps1=0`, `ps1_ready=1`.
  - Else, if the youngest lane i<j with `disp_valid[i]`, `disp_rd[i]==rs1`, rd≠0 exists: `ps1=disp_pd[i]`, `ps1_ready=0`.
  - Else `ps1=map[rs1]`, and `ps1_ready=rdy[rs1]` OR (CDB bypass hit, see Configuration).
- Rename commit, each cycle without flush: for every valid lane with rd≠0, `map[rd]<=pd` and `rdy[rd]<=0`. If several lanes share an rd, the highest lane wins.
- CDB wakeup: for each valid port p with `map[cdb_arch[p]]==cdb_phys[p]`, set `rdy[cdb_arch[p]]<=1`. The match uses the pre-update map. A rename of the same arch register in the same cycle overrides the wakeup, leaving it at 0.
- Checkpoint take: when `disp_ckpt[k]` is set, write `cmap[tail]`/`crdy[tail]` with the map and ready image after lanes 0..k and this cycle's CDB wakeups. Lanes >k are excluded. Then `tail<=tail+1`.
- Checkpoint wakeup: every cycle, each live slot s sets `crdy[s][a]` for each CDB port whose `cdb_phys` matches `cmap[s][a]`, with `a=cdb_arch`.
- Release: `head<=head+1` when `ckpt_release`. Releasing while empty is a protocol violation; pointers are unchanged.
- Flush:
  - `map<=cmap[flush_ckpt_id]`.
  - `rdy<=crdy[flush_ckpt_id]` OR this cycle's CDB wakeups matched against the restored map.
  - `tail<=flush_ckpt_id` with the MSB chosen so that head..tail remains ordered; this frees that slot and all younger slots.
  - Dispatch lanes are ignored in the flush cycle.
  - `ckpt_release` in the same cycle is honoured. `flush_ckpt_id==head` together with release is illegal.
- `ckpt_full = (tail-head)==CKPT_DEPTH`. Asserting `disp_ckpt` while full is a violation; decode stalls, and the block drops the snapshot without moving the pointers.

## Timing
- Lookups are combinational from registered state plus the same-cycle lane and CDB inputs, with zero latency.
- All state updates land on the rising `clk`. Renames are visible to the next cycle's lookups.
- Flush restoration is visible the cycle after `flush_valid`.
- Asynchronous `rst` mid-operation immediately forces the reset state; pending checkpoints are lost.
- Pointer wrap-around is modulo 2·CKPT_DEPTH on CKPT_W+1 bits.

## Configuration
- `RAT_CDB_BYPASS_EN` defined: the same-cycle CDB match against `map[rs]` forces ready=1 on the lookup outputs.
- `RAT_CDB_BYPASS_EN` undefined: ready reflects registered `rdy` only, so a wakeup becomes visible one cycle later. State update behaviour is identical in both builds.

## Test plan
- Reset, then lane0 rs1=5 → ps1=5, ready=1; rd=0 with pd=40 → map[0] stays 0.
- Lane0 rd=3/pd=33; lane1 rs1=3 in the same cycle → lane1 ps1=33, ready=0. Next cycle rs1=3 → 33, ready=0.
- Both lanes rd=7 (pd 40, 41) → map[7]=41. A CDB in a later cycle with arch=7, phys=40 leaves rdy[7]=0. CDB with phys=41 sets rdy=1; with the bypass build, the lookup ready=1 in the same cycle.
- Lane0 rd=4/pd=44, lane1 branch ckpt; next cycle rd=4/pd=50; flush to that id → map[4]=44. A CDB for phys 44 while the slot is live → restored rdy[4]=1.
- Four checkpoints → ckpt_full=1. One release → full=0, head=1. Wraps correctly after 8 allocations.
- Assert rst mid-flush → map identity, rdy all 1, pointers 0 immediately.

Source files
------------

// File: rtl/rename_map_nway.sv
// rename_map_nway: multi-lane register alias table with a circular store of
// branch checkpoints for single-cycle mispredict recovery.
// Lanes are renamed oldest-first (lane 0 oldest). Readiness is tracked per
// architectural register and woken by the CDB broadcast ports.
// Optional build macro RAT_CDB_BYPASS_EN: a same-cycle CDB match also forces
// the lookup ready outputs high. Without it, a wakeup shows up one cycle later.
module rename_map_nway #(
  parameter int PHYS_W     = 6,
  parameter int DISPATCH_W = 2,
  parameter int CDB_PORTS  = 4,
  parameter int CKPT_DEPTH = 4,
  parameter int CKPT_W     = $clog2(CKPT_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DISPATCH_W-1:0]                 disp_valid,
  input  logic [DISPATCH_W-1:0][4:0]            disp_rs1,
  input  logic [DISPATCH_W-1:0][4:0]            disp_rs2,
  input  logic [DISPATCH_W-1:0][4:0]            disp_rd,
  input  logic [DISPATCH_W-1:0][PHYS_W-1:0]     disp_pd,
  input  logic [DISPATCH_W-1:0]                 disp_ckpt,
  output logic [DISPATCH_W-1:0][PHYS_W-1:0]     ps1,
  output logic [DISPATCH_W-1:0][PHYS_W-1:0]     ps2,
  output logic [DISPATCH_W-1:0]                 ps1_ready,
  output logic [DISPATCH_W-1:0]                 ps2_ready,
  output logic [CKPT_W-1:0]                     ckpt_alloc_id,
  output logic                                  ckpt_full,
  input  logic [CDB_PORTS-1:0]                  cdb_valid,
  input  logic [CDB_PORTS-1:0][4:0]             cdb_arch,
  input  logic [CDB_PORTS-1:0][PHYS_W-1:0]      cdb_phys,
  input  logic                                  ckpt_release,
  input  logic                                  flush_valid,
  input  logic [CKPT_W-1:0]                     flush_ckpt_id
);

`ifdef RAT_CDB_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif
  localparam int PW = CKPT_W + 1;

  logic [31:0][PHYS_W-1:0] rat_map, map_n, snap_map;
  logic [31:0]             rat_rdy, rdy_n, snap_rdy, wake;
  logic [31:0][PHYS_W-1:0] cmap [CKPT_DEPTH];
  logic [31:0]             crdy [CKPT_DEPTH];
  logic [CKPT_DEPTH-1:0][31:0] cwake;
  logic [CKPT_DEPTH-1:0]   live;
  logic [CKPT_W:0]         head, tail, head_n, tail_n, count;
  logic                    snap_take, take, empty;

  // True when any valid CDB port broadcasts (arch a, phys p).
  function automatic logic cdb_hit(input logic [4:0] a, input logic [PHYS_W-1:0] p,
                                   input logic [CDB_PORTS-1:0] v,
                                   input logic [CDB_PORTS-1:0][4:0] ca,
                                   input logic [CDB_PORTS-1:0][PHYS_W-1:0] cp);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < CDB_PORTS; i++)
      if (v[i] && ca[i] == a && cp[i] == p) hit = 1'b1;
    return hit;
  endfunction

  // Checkpoint occupancy, liveness of each slot, and CDB wakeup vectors for
  // the live map and every checkpoint image.
  always_comb begin
    count         = tail - head;
    empty         = (count == '0);
    ckpt_full     = (count == PW'(CKPT_DEPTH));
    ckpt_alloc_id = tail[CKPT_W-1:0];
    for (int a = 0; a < 32; a++)
      wake[a] = cdb_hit(5'(a), rat_map[a], cdb_valid, cdb_arch, cdb_phys);
    for (int s = 0; s < CKPT_DEPTH; s++) begin
      live[s] = {1'b0, CKPT_W'(s) - head[CKPT_W-1:0]} < count;
      for (int a = 0; a < 32; a++)
        cwake[s][a] = cdb_hit(5'(a), cmap[s][a], cdb_valid, cdb_arch, cdb_phys);
    end
  end

  // Source lookup: table read, overridden by the youngest older lane writing
  // the same register, and x0 always reads as ready physical 0.
  always_comb begin
    for (int j = 0; j < DISPATCH_W; j++) begin
      ps1[j]       = rat_map[disp_rs1[j]];
      ps1_ready[j] = rat_rdy[disp_rs1[j]] |
                     (BYPASS & cdb_hit(disp_rs1[j], rat_map[disp_rs1[j]], cdb_valid, cdb_arch, cdb_phys));
      ps2[j]       = rat_map[disp_rs2[j]];
      ps2_ready[j] = rat_rdy[disp_rs2[j]] |
                     (BYPASS & cdb_hit(disp_rs2[j], rat_map[disp_rs2[j]], cdb_valid, cdb_arch, cdb_phys));
      for (int i = 0; i < j; i++) begin
        if (disp_valid[i] && disp_rd[i] != '0 && disp_rd[i] == disp_rs1[j]) begin
          ps1[j]       = disp_pd[i];
          ps1_ready[j] = 1'b0;
        end
        if (disp_valid[i] && disp_rd[i] != '0 && disp_rd[i] == disp_rs2[j]) begin
          ps2[j]       = disp_pd[i];
          ps2_ready[j] = 1'b0;
        end
      end
      if (disp_rs1[j] == '0) begin
        ps1[j]       = '0;
        ps1_ready[j] = 1'b1;
      end
      if (disp_rs2[j] == '0) begin
        ps2[j]       = '0;
        ps2_ready[j] = 1'b1;
      end
    end
  end

  // Next map/ready image: wakeups first, then renames in lane order so a
  // rename beats a wakeup and the highest lane wins. The snapshot is taken
  // right after the branch lane; a flush replaces everything with the image.
  always_comb begin
    map_n     = rat_map;
    rdy_n     = rat_rdy | wake;
    snap_map  = map_n;
    snap_rdy  = rdy_n;
    snap_take = 1'b0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (disp_valid[k] && disp_rd[k] != '0) begin
        map_n[disp_rd[k]] = disp_pd[k];
        rdy_n[disp_rd[k]] = 1'b0;
      end
      if (disp_ckpt[k]) begin
        snap_map  = map_n;
        snap_rdy  = rdy_n;
        snap_take = 1'b1;
      end
    end
    if (flush_valid) begin
      map_n     = cmap[flush_ckpt_id];
      rdy_n     = crdy[flush_ckpt_id] | cwake[flush_ckpt_id];
      snap_take = 1'b0;
    end
    take   = snap_take & ~ckpt_full;
    head_n = head;
    if (ckpt_release && !empty) head_n = head + PW'(1);
    // The restored tail keeps the head's lap bit unless the id lies behind
    // the head in slot order, in which case it is on the next lap.
    if (flush_valid)
      tail_n = {(flush_ckpt_id < head[CKPT_W-1:0]) ? ~head[CKPT_W] : head[CKPT_W], flush_ckpt_id};
    else if (take)
      tail_n = tail + PW'(1);
    else
      tail_n = tail;
  end

  // State registers: live table, pointers, checkpoint images with wakeups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) rat_map[a] <= PHYS_W'(a);
      rat_rdy <= '1;
      head    <= '0;
      tail    <= '0;
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        cmap[s] <= '0;
        crdy[s] <= '0;
      end
    end else begin
      rat_map <= map_n;
      rat_rdy <= rdy_n;
      head    <= head_n;
      tail    <= tail_n;
      for (int s = 0; s < CKPT_DEPTH; s++)
        crdy[s] <= crdy[s] | ({32{live[s]}} & cwake[s]);
      if (take) begin
        cmap[tail[CKPT_W-1:0]] <= snap_map;
        crdy[tail[CKPT_W-1:0]] <= snap_rdy;
      end
    end
  end

endmodule
